// File: rtl/pa_fpu.sv
// Shared FPU definitions: operation codes, request-sequencer states and the
// FPU register map used by the byte-wide chip-select bus.
package pa_fpu;

  typedef enum logic [3:0] {
    op_add = 4'h0,
    op_sub = 4'h1,
    op_mul = 4'h2,
    op_div = 4'h3
  } e_fpu_operation;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WR_SETUP,
    WR_STROBE,
    SETTLE,
    RD_SETUP,
    RD_SAMPLE,
    DONE
  } e_fpu_seq_state;

  localparam logic [5:0] FPU_ADDR_A0   = 6'd0;
  localparam logic [5:0] FPU_ADDR_B0   = 6'd4;
  localparam logic [5:0] FPU_ADDR_OP   = 6'd8;
  localparam logic [5:0] FPU_ADDR_RES0 = 6'd9;

  function automatic logic fpu_op_valid(input logic [3:0] op);
    case (op)
      op_add, op_sub, op_mul, op_div: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins, a tie goes to the
// requester that was not granted last time.
module fpu_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/fpu_req_sequencer.sv
// Two-port front end for the memory-mapped FPU: arbitrates, writes operand and
// op bytes, waits for the FPU to settle, then reads back the 32-bit result.
module fpu_req_sequencer
  import pa_fpu::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        req_0,
  input  logic        req_1,
  input  logic [31:0] a_0,
  input  logic [31:0] a_1,
  input  logic [31:0] b_0,
  input  logic [31:0] b_1,
  input  logic [3:0]  op_0,
  input  logic [3:0]  op_1,
  output logic        ack_0,
  output logic        ack_1,
  output logic        done_0,
  output logic        done_1,
  output logic [31:0] result,
  output logic        err,
  output logic        busy,
  output logic [5:0]  fpu_addr,
  output logic [7:0]  fpu_data_out,
  input  logic [7:0]  fpu_data_in,
  output logic        fpu_cs_n,
  output logic        fpu_wr_n,
  output logic        fpu_rd_n
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  e_fpu_seq_state state_reg, state_next;
  logic        winner_reg;
  logic        last_reg;
  logic [31:0] a_reg, b_reg;
  logic [3:0]  op_reg;
  logic [3:0]  idx_reg;
  logic [1:0]  ridx_reg;
  logic [7:0]  cnt_reg;
  logic [31:0] result_reg;
  logic        err_reg;
  logic [1:0]  gnt;
  logic [3:0]  sel_op;
  logic [7:0]  wr_byte;

  fpu_rr_arb2 u_arb (
    .req  ({req_1, req_0}),
    .last (last_reg),
    .gnt  (gnt)
  );

  assign sel_op = winner_reg ? op_1 : op_0;
  assign result = result_reg;
  assign busy   = (state_reg != IDLE);
  assign err    = (state_reg == DONE) && err_reg;

  // Operand bytes go out least-significant first, A then B, then the op code.
  always_comb begin
    wr_byte = {4'h0, op_reg};
    if (idx_reg < FPU_ADDR_B0[3:0]) begin
      wr_byte = a_reg[{idx_reg[1:0], 3'b000} +: 8];
    end else if (idx_reg < FPU_ADDR_OP[3:0]) begin
      wr_byte = b_reg[{idx_reg[1:0], 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg  <= IDLE;
      winner_reg <= 1'b0;
      last_reg   <= 1'b1;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      idx_reg    <= '0;
      ridx_reg   <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (|gnt) winner_reg <= gnt[1];
        end
        GRANT: begin
          a_reg    <= winner_reg ? a_1 : a_0;
          b_reg    <= winner_reg ? b_1 : b_0;
          op_reg   <= sel_op;
          last_reg <= winner_reg;
          err_reg  <= !fpu_op_valid(sel_op);
          idx_reg  <= '0;
          ridx_reg <= '0;
        end
        WR_STROBE: begin
          if (idx_reg == FPU_ADDR_OP[3:0]) cnt_reg <= SETTLE_LOAD;
          else                             idx_reg <= idx_reg + 4'd1;
        end
        SETTLE: begin
          if (cnt_reg != 8'd0) cnt_reg <= cnt_reg - 8'd1;
        end
        RD_SAMPLE: begin
          result_reg[{ridx_reg, 3'b000} +: 8] <= fpu_data_in;
          ridx_reg <= ridx_reg + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next   = state_reg;
    ack_0        = 1'b0;
    ack_1        = 1'b0;
    done_0       = 1'b0;
    done_1       = 1'b0;
    fpu_cs_n     = 1'b1;
    fpu_wr_n     = 1'b1;
    fpu_rd_n     = 1'b1;
    fpu_addr     = '0;
    fpu_data_out = '0;
    case (state_reg)
      IDLE: begin
        if (|gnt) state_next = GRANT;
      end
      GRANT: begin
        ack_0      = !winner_reg;
        ack_1      = winner_reg;
        state_next = fpu_op_valid(sel_op) ? WR_SETUP : DONE;
      end
      WR_SETUP: begin
        fpu_cs_n     = 1'b0;
        fpu_addr     = FPU_ADDR_A0 + {2'b00, idx_reg};
        fpu_data_out = wr_byte;
        state_next   = WR_STROBE;
      end
      WR_STROBE: begin
        fpu_cs_n     = 1'b0;
        fpu_wr_n     = 1'b0;
        fpu_addr     = FPU_ADDR_A0 + {2'b00, idx_reg};
        fpu_data_out = wr_byte;
        state_next   = (idx_reg == FPU_ADDR_OP[3:0]) ? SETTLE : WR_SETUP;
      end
      SETTLE: begin
        if (cnt_reg == 8'd0) state_next = RD_SETUP;
      end
      RD_SETUP: begin
        fpu_cs_n   = 1'b0;
        fpu_addr   = FPU_ADDR_RES0 + {4'b0000, ridx_reg};
        state_next = RD_SAMPLE;
      end
      RD_SAMPLE: begin
        fpu_cs_n   = 1'b0;
        fpu_rd_n   = 1'b0;
        fpu_addr   = FPU_ADDR_RES0 + {4'b0000, ridx_reg};
        state_next = (ridx_reg == 2'd3) ? DONE : RD_SETUP;
      end
      DONE: begin
        done_0     = !winner_reg;
        done_1     = winner_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/fpu_req_sequencer.md
# fpu_req_sequencer

Two-port front end for the memory-mapped `fpu`. It arbitrates round-robin between two requesters, each presenting a full 32-bit operand pair plus an operation code. For the winning request it sequences the FPU's 8-bit chip-select bus: writes operand bytes, writes the operation byte, waits a settle period, then reads back the 4 result bytes. It returns the assembled 32-bit result with a one-cycle done pulse. It sits between the CPU-side coprocessor port / microcode engine and the single `fpu` instance.

## Interface
- `SETTLE_CYCLES`, default 4: idle cycles between the operation-byte write and the first result read; legal range 1–255.
- `clk`  in  1  system clock; all state on rising edge.
- `arst_n`  in  1  asynchronous active-low reset.
- `req_0`, `req_1`  in  1 each  request, held high until the matching `ack_x`.
- `a_0`, `a_1`  in  32 each  operand A, stable while `req_x` is high.
- `b_0`, `b_1`  in  32 each  operand B, stable while `req_x` is high.
- `op_0`, `op_1`  in  4 each  `e_fpu_operation` code, stable while `req_x` is high.
- `ack_0`, `ack_1`  out  1 each  one-cycle grant pulse; operands are captured in that cycle.
- `done_0`, `done_1`  out  1 each  one-cycle completion pulse to the granted requester.
- `result`  out  32  result word; valid while `done_x` is high, held until the next done.
- `err`  out  1  high with `done_x` when the op code is invalid.
- `busy`  out  1  high from the grant cycle through the done cycle.
- `fpu_addr`  out  6  FPU register address.
- `fpu_data_out`  out  8  write data to the FPU.
- `fpu_data_in`  in  8  read data from the FPU.
- `fpu_cs_n`, `fpu_wr_n`, `fpu_rd_n`  out  1 each  active-low strobes.

## Operation
- States (`e_fpu_seq_state`):
  - `IDLE`: arbitrates; on any request goes to `GRANT`.
  - `GRANT`: latches the winner's A, B, op and winner id, and pulses `ack_x`.
    - Valid op (`op_add`, `op_sub`, `op_mul`, `op_div`) → `WR_SETUP`.
    - Invalid op → `DONE` with `err`=1, no bus traffic, `result` unchanged.
  - `WR_SETUP` / `WR_STROBE`: 2 cycles per byte. Byte index `idx` 0..8 maps to:
    - `fpu_addr` = `idx`.
    - Data: idx 0–3 = A[7:0]..A[31:24]; 4–7 = B[7:0]..B[31:24]; 8 = {4'h0, op}.
    - After `idx`=8 → `SETTLE`.
  - `SETTLE`: counter loads `SETTLE_CYCLES`-1 and decrements to 0; strobes inactive; then → `RD_SETUP`.
  - `RD_SETUP` / `RD_SAMPLE`: 2 cycles per byte, `fpu_addr` = 9 + `ridx`, `ridx` 0..3.
    - In `RD_SAMPLE`, `fpu_data_in` is registered into `result[8*ridx+7 -: 8]`.
    - After `ridx`=3 → `DONE`.
  - `DONE`: pulses `done_x` of the latched winner → `IDLE`.
- Bus strobes:
  - Setup cycle: `fpu_cs_n`=0 with wr/rd high.
  - Strobe/sample cycle: `fpu_wr_n`=0 (write) or `fpu_rd_n`=0 (read).
  - All strobes are high in `IDLE`, `GRANT`, `SETTLE` and `DONE`.
  - Address and data are stable across both cycles of an access.
- Arbitration:
  - Round-robin with a 1-bit `last` register, reset to 1, so requester 0 wins the first tie.
  - A lone requester always wins.
  - On a tie, the requester not equal to `last` wins; `last` updates in `GRANT`.
  - Requests are only sampled in `IDLE`; a loser stays pending, un-acked.

## Timing
- Reset values: all `ack_x`, `done_x`, `err`, `busy` = 0; `result` = 0; `fpu_cs_n`, `fpu_wr_n`, `fpu_rd_n` = 1; `fpu_addr` = 0; `fpu_data_out` = 0; state `IDLE`; `last` = 1.
- `req_x` seen in `IDLE` at cycle 0 gives:
  - `ack_x` at cycle 1.
  - Writes on cycles 2–19.
  - `SETTLE` on cycles 20..19+S.
  - Reads on cycles 20+S..27+S.
  - `done_x` at cycle 28+S (32 for the default).
- Invalid op: `ack_x` at cycle 1, `done_x` + `err` at cycle 2.
- Back-to-back: a request pending during `DONE` is arbitrated in the following `IDLE` cycle, giving a minimum 2-cycle gap between a done pulse and the next ack.
- Reset asserted mid-transaction: strobes go high immediately (asynchronously) and no done is issued; the requester must re-request.
- A requester dropping `req_x` before ack is legal; nothing is issued for it.

## Structure
- Add to `pa_fpu`:
  - `e_fpu_seq_state`.
  - Address constants `FPU_ADDR_A0`=0, `FPU_ADDR_B0`=4, `FPU_ADDR_OP`=8, `FPU_ADDR_RES0`=9.
- Reuse `e_fpu_operation` from `pa_fpu`.
- Sub-module `fpu_rr_arb2`: 2-way round-robin, inputs `req[1:0]`/`last`, outputs one-hot `gnt[1:0]`, purely combinational. `last` stays in the parent.

## Test plan
- Requester 0 sends `op_add`, A=32'h3FC00000 (1.5), B=32'h40100000 (2.25) → `ack_0` at cycle 1, `done_0` at cycle 32, `result`=32'h40700000 (3.75), `err`=0.
- Requester 1 sends `op_mul`, A=32'h40000000 (2.0), B=32'h40400000 (3.0) → bus monitor sees writes 00,00,00,40,00,00,40,40 then op byte at addr 8; `done_1`, `result`=32'h40C00000.
- Both requesters raise req in the same cycle, twice in a row → grant order 0, 1, 0; each done goes only to its own requester.
- op=4'hF on requester 0 → `ack_0` at cycle 1, `done_0`+`err` at cycle 2, no `fpu_cs_n` low, `result` unchanged.
- `arst_n` pulsed low during `WR_STROBE` of byte 5 → strobes high that cycle, no done, `busy`=0; a fresh request then completes normally.
- `SETTLE_CYCLES`=1 → `done_x` at cycle 29; strobe pairs stay 2 cycles each throughout.
